// File: rtl/ahb_mem_slave_p.sv
// Parametrised AHB memory slave: configurable width, depth and wait states, lane-accurate read data,
// two-cycle ERROR response and same-word write-to-read forwarding. Optional macro: AHB_MEM_SEQ_FAST_EN.
module ahb_mem_slave_p #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_BITS   = 20,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic                  HREADYin,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYout,
  output logic [1:0]            HRESP
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IW    = ADDR_BITS - LSB;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IW-1:0]         idx_q;
  logic                  write_q;
  logic [NB-1:0]         mask_q;
  logic [DATA_WIDTH-1:0] rd_word_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_VALUE};

  logic                  accept, start, legal, commit;
  logic [2:0]            size_mask;
  logic [NB-1:0]         lane_d;
  logic [IW-1:0]         haddr_idx, rd_idx;
  logic [3:0]            wait_load;
  logic [DATA_WIDTH-1:0] fwd_word;

`ifdef AHB_MEM_SEQ_FAST_EN
  assign wait_load = (HTRANS == 2'b11) ? 4'd0 : 4'(WAIT_STATES);
`else
  assign wait_load = 4'(WAIT_STATES);
`endif

  assign accept    = HSEL & HREADYin & ((HTRANS == 2'b10) | (HTRANS == 2'b11));
  assign start     = accept & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR2));
  assign haddr_idx = HADDR[ADDR_BITS-1:LSB];
  assign rd_idx    = start ? haddr_idx : idx_q;
  assign commit    = (state_q == S_DONE) & write_q & ~HRESET;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    size_mask = 3'b111;
    case (HSIZE)
      3'd0:    size_mask = 3'b000;
      3'd1:    size_mask = 3'b001;
      3'd2:    size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
    legal = ~(|HADDR[31:ADDR_BITS]) & (HSIZE <= 3'(LSB)) & ~(|(HADDR[2:0] & size_mask));
    lane_d = '0;
    for (int b = 0; b < NB; b++)
      lane_d[b] = (((b ^ int'(HADDR[LSB-1:0])) >> HSIZE) == 0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_DONE;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (start) begin
          if (!legal)                 state_d = S_ERR1;
          else if (wait_load == 4'd0) state_d = S_DONE;
          else                        state_d = S_WAIT;
          cnt_d = wait_load;
        end
      end
    endcase
  end

  // Read word for the beat heading into DONE, merged with a write committing to the same word.
  always_comb begin
    fwd_word = mem[rd_idx];
    if (commit && (idx_q == rd_idx))
      for (int b = 0; b < NB; b++)
        if (mask_q[b]) fwd_word[8*b +: 8] = HWDATA[8*b +: 8];
  end

  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (HRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      mask_q    <= '0;
      rd_word_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_word_q <= fwd_word;
      if (start) begin
        idx_q   <= haddr_idx;
        write_q <= HWRITE;
        mask_q  <= lane_d;
      end
    end
  end

  // NOTE: the memory array has no reset; contents must survive HRESET.
  always_ff @(posedge HCLK) begin
    if (commit)
      for (int b = 0; b < NB; b++)
        if (mask_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
  end

  always_comb begin
    HRDATA = '0;
    if ((state_q == S_DONE) && !write_q)
      for (int b = 0; b < NB; b++)
        if (mask_q[b]) HRDATA[8*b +: 8] = rd_word_q[8*b +: 8];
  end

  assign HREADYout = ~((state_q == S_WAIT) | (state_q == S_ERR1));
  assign HRESP     = ((state_q == S_ERR1) | (state_q == S_ERR2)) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_ahb_mem_slave_p.sv
// Directed bench for ahb_mem_slave_p: three instances (32-bit zero-wait, 32-bit three-wait, 64-bit)
// share one bus; act selects which slave owns HSEL and drives the bus HREADY.
module tb_ahb_mem_slave_p;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] hwdata;
  logic        force_low;
  int          act;

  logic [31:0] d0_rd, d1_rd;
  logic [63:0] d2_rd;
  logic        d0_rdy, d1_rdy, d2_rdy;
  logic [1:0]  d0_resp, d1_resp, d2_resp;

  logic        hready_in;
  logic [63:0] rd_bus;
  logic        rdy_bus;
  logic [1:0]  resp_bus;

  int total = 0;
  int bad   = 0;

  logic [63:0] rdata, first_data;
  logic [1:0]  resp;
  int          waits, cyc, done_b, nb;
  logic        rdy_s;

`ifdef AHB_MEM_SEQ_FAST_EN
  localparam int BURST_CYC = 7;
`else
  localparam int BURST_CYC = 16;
`endif

  always #5 hclk = ~hclk;

  assign rdy_bus   = (act == 0) ? d0_rdy : (act == 1) ? d1_rdy : d2_rdy;
  assign resp_bus  = (act == 0) ? d0_resp : (act == 1) ? d1_resp : d2_resp;
  assign rd_bus    = (act == 0) ? {32'h0, d0_rd} : (act == 1) ? {32'h0, d1_rd} : d2_rd;
  assign hready_in = force_low ? 1'b0 : rdy_bus;

  ahb_mem_slave_p #(.DATA_WIDTH(32), .ADDR_BITS(20), .WAIT_STATES(0), .INIT_VALUE(32'hA5A5_A5A5)) u_d0 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HREADYin(hready_in), .HWDATA(hwdata[31:0]), .HRDATA(d0_rd),
    .HREADYout(d0_rdy), .HRESP(d0_resp));

  ahb_mem_slave_p #(.DATA_WIDTH(32), .ADDR_BITS(20), .WAIT_STATES(3)) u_d1 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HREADYin(hready_in), .HWDATA(hwdata[31:0]), .HRDATA(d1_rd),
    .HREADYout(d1_rdy), .HRESP(d1_resp));

  ahb_mem_slave_p #(.DATA_WIDTH(64), .ADDR_BITS(20), .WAIT_STATES(0)) u_d2 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HREADYin(hready_in), .HWDATA(hwdata), .HRDATA(d2_rd),
    .HREADYout(d2_rdy), .HRESP(d2_resp));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // Single non-pipelined transfer; waits counts data-phase cycles with HREADYout low.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [63:0] wdata, output logic [63:0] rd, output logic [1:0] rsp,
                      output int nwait);
    hsel = 3'b001 << act; haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size;
    step();
    hsel = '0; htrans = 2'b00; hwdata = wdata;
    nwait = 0; rd = '0; rsp = 2'b11;
    for (int i = 0; i < 32; i++) begin
      @(negedge hclk);
      if (rdy_bus) begin
        rd = rd_bus; rsp = resp_bus;
        break;
      end
      nwait++;
      step();
    end
    step();
  endtask

  task automatic err_xfer(input string tag, input logic [31:0] addr, input logic wr,
                          input logic [2:0] size);
    hsel = 3'b001 << act; haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size;
    step();
    hsel = '0; htrans = 2'b00; hwdata = '1;
    @(negedge hclk);
    check({tag, "_err1_ready"}, 64'(rdy_bus), 64'd0);
    check({tag, "_err1_resp"}, 64'(resp_bus), 64'd1);
    step();
    @(negedge hclk);
    check({tag, "_err2_ready"}, 64'(rdy_bus), 64'd1);
    check({tag, "_err2_resp"}, 64'(resp_bus), 64'd1);
    check({tag, "_err2_rdata"}, rd_bus, 64'd0);
    step();
    @(negedge hclk);
    check({tag, "_after_resp"}, 64'(resp_bus), 64'd0);
    step();
  endtask

  initial begin
    hreset = 1'b1; hsel = '0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
    hwdata = '0; force_low = 1'b0; act = 0;
    step(); step();
    hreset = 1'b0;
    @(negedge hclk);
    check("reset_ready", 64'(d0_rdy), 64'd1);
    check("reset_resp", 64'(d0_resp), 64'd0);
    check("reset_rdata", 64'(d0_rd), 64'd0);
    check("reset_ready_d1", 64'(d1_rdy), 64'd1);
    check("reset_ready_d2", 64'(d2_rdy), 64'd1);
    step();

    // Word write then byte merge on the zero-wait 32-bit slave.
    xfer(32'h100, 1'b1, 3'd2, 64'hDEAD_BEEF, rdata, resp, waits);
    check("wr_word_waits", 64'(waits), 64'd0);
    check("wr_word_resp", 64'(resp), 64'd0);
    xfer(32'h102, 1'b1, 3'd0, 64'h0055_0000, rdata, resp, waits);
    xfer(32'h100, 1'b0, 3'd2, 64'h0, rdata, resp, waits);
    check("rd_word_merged", rdata, 64'hDE55_BEEF);
    xfer(32'h102, 1'b0, 3'd1, 64'h0, rdata, resp, waits);
    check("rd_half_102", rdata, 64'hDE55_0000);
    xfer(32'h101, 1'b0, 3'd0, 64'h0, rdata, resp, waits);
    check("rd_byte_101", rdata, 64'h0000_BE00);

    // Illegal transfers: out of range, misaligned, oversize; memory must not change.
    err_xfer("oor_read", 32'h0010_0000, 1'b0, 3'd2);
    err_xfer("oor_write", 32'h0010_0100, 1'b1, 3'd2);
    err_xfer("misaligned_half", 32'h101, 1'b1, 3'd1);
    err_xfer("dword_on_32", 32'h100, 1'b1, 3'd3);
    xfer(32'h100, 1'b0, 3'd2, 64'h0, rdata, resp, waits);
    check("after_err_unchanged", rdata, 64'hDE55_BEEF);

    // Write immediately followed by a read of the same word.
    act = 0;
    hsel = 3'b001; haddr = 32'h200; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    step();
    hwdata = 64'h1122_3344; hwrite = 1'b0;
    @(negedge hclk);
    check("fwd_wr_ready", 64'(d0_rdy), 64'd1);
    step();
    hsel = '0; htrans = 2'b00;
    @(negedge hclk);
    check("fwd_full_word", 64'(d0_rd), 64'h1122_3344);
    step();
    hsel = 3'b001; haddr = 32'h201; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd0;
    step();
    hwdata = 64'h0000_7700; haddr = 32'h200; hwrite = 1'b0; hsize = 3'd2;
    step();
    hsel = '0; htrans = 2'b00;
    @(negedge hclk);
    check("fwd_byte_merge", 64'(d0_rd), 64'h1122_7744);
    step();

    // Reset during a write DONE abandons the write.
    hsel = 3'b001; haddr = 32'h300; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    step();
    hsel = '0; htrans = 2'b00; hwdata = 64'h1234_5678; hreset = 1'b1;
    step();
    hreset = 1'b0;
    @(negedge hclk);
    check("midreset_ready", 64'(d0_rdy), 64'd1);
    check("midreset_resp", 64'(d0_resp), 64'd0);
    step();
    xfer(32'h300, 1'b0, 3'd2, 64'h0, rdata, resp, waits);
    check("midreset_keeps_init", rdata, 64'hA5A5_A5A5);

    // Bus HREADY low: address phase must be ignored.
    force_low = 1'b1;
    hsel = 3'b001; haddr = 32'h100; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    step();
    force_low = 1'b0; hsel = '0; htrans = 2'b00;
    @(negedge hclk);
    check("hready_low_no_accept_ready", 64'(d0_rdy), 64'd1);
    check("hready_low_no_accept_rdata", 64'(d0_rd), 64'd0);
    step();

    // Three-wait slave: single NONSEQ transfers.
    act = 1;
    xfer(32'h40, 1'b1, 3'd2, 64'hCAFE_F00D, rdata, resp, waits);
    check("ws3_write_waits", 64'(waits), 64'd3);
    xfer(32'h40, 1'b0, 3'd2, 64'h0, rdata, resp, waits);
    check("ws3_read_waits", 64'(waits), 64'd3);
    check("ws3_read_data", rdata, 64'hCAFE_F00D);
    check("ws3_read_resp", 64'(resp), 64'd0);

    // Four-beat INCR read burst: total data-phase cycles.
    hsel = 3'b010; haddr = 32'h40; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    step();
    haddr = 32'h44; htrans = 2'b11; nb = 2;
    cyc = 0; done_b = 0; first_data = '0;
    while (done_b < 4 && cyc < 64) begin
      @(negedge hclk);
      cyc++;
      rdy_s = rdy_bus;
      if (rdy_s) begin
        if (done_b == 0) first_data = rd_bus;
        done_b++;
      end
      step();
      if (rdy_s) begin
        if (nb < 4) begin
          haddr = 32'h40 + 32'(4 * nb); htrans = 2'b11; nb++;
        end else begin
          hsel = '0; htrans = 2'b00;
        end
      end
    end
    check("burst_beats", 64'(done_b), 64'd4);
    check("burst_cycles", 64'(cyc), 64'(BURST_CYC));
    check("burst_first_data", first_data, 64'hCAFE_F00D);

    // 64-bit slave: dword write, lane-accurate narrow reads, illegal sizes.
    act = 2;
    xfer(32'h8, 1'b1, 3'd3, 64'h0102_0304_0506_0708, rdata, resp, waits);
    check("d64_write_resp", 64'(resp), 64'd0);
    xfer(32'hD, 1'b0, 3'd0, 64'h0, rdata, resp, waits);
    check("d64_byte_0xD", rdata, 64'h0000_0300_0000_0000);
    xfer(32'hC, 1'b0, 3'd2, 64'h0, rdata, resp, waits);
    check("d64_word_0xC", rdata, 64'h0102_0304_0000_0000);
    xfer(32'h8, 1'b0, 3'd3, 64'h0, rdata, resp, waits);
    check("d64_dword_0x8", rdata, 64'h0102_0304_0506_0708);
    err_xfer("d64_misaligned_dword", 32'h4, 1'b0, 3'd3);
    err_xfer("d64_size4", 32'h0, 1'b0, 3'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_mem_slave_p.md
Name: ahb_mem_slave_p

Overview:
- Parametrised next-generation behavioural AHB memory slave for the project test benches and SoC shells.
- Generalises the existing 32-bit memory model:
  - configurable data width, depth and wait states
  - proper byte-lane read data
  - two-cycle ERROR responses for illegal transfers
  - same-word write-to-read forwarding
- Sits on an AHB slave port behind the decoder (HSEL) and is shared with other slaves via HREADYin.

Parameters:
- DATA_WIDTH, 32, bus width in bits; legal values 32 or 64.
- ADDR_BITS, 20, byte-address bits decoded; memory holds 2**ADDR_BITS bytes.
- WAIT_STATES, 0, wait cycles inserted on each NONSEQ/SEQ data phase; legal 0..15.
- INIT_VALUE, 0, value of every memory word at time zero. Memory is not cleared by reset.

Ports:
- HCLK  in  1  bus clock; all state updates on its rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 half, 010 word, 011 dword (dword legal only when DATA_WIDTH=64).
- HREADYin  in  1  bus-level HREADY.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HRDATA  out  DATA_WIDTH  read data.
- HREADYout  out  1  slave ready.
- HRESP  out  2  OKAY=00, ERROR=01. RETRY and SPLIT are never issued.

Behaviour:
- Reset (HRESET=1 at a clock edge):
  - HREADYout=1, HRESP=OKAY, HRDATA=0.
  - Data-phase state cleared; the state machine goes to IDLE.
  - Memory contents are retained.
  - Reset mid-transfer abandons the transfer; a pending write is not committed.
- Address-phase accept: occurs when HSEL & HREADYin & HTRANS[1] at a rising edge. On accept, register HADDR, HWRITE, HSIZE and the lane mask.
- IDLE/BUSY, or not selected: no data phase; the next cycle is zero-wait OKAY.
- Illegal transfer: address >= 2**ADDR_BITS, or HSIZE above the bus width, or address misaligned for HSIZE.
  - State ERR1: HREADYout=0, HRESP=ERROR.
  - State ERR2: HREADYout=1, HRESP=ERROR.
  - Then IDLE or the next accepted transfer.
  - No memory change.
- Legal transfer, state WAIT:
  - The counter loads WAIT_STATES; HREADYout=0 while the counter is non-zero, decrementing each cycle.
  - At zero, state DONE: HREADYout=1, HRESP=OKAY.
  - WAIT_STATES=0 gives DONE in the first data-phase cycle.
- States: IDLE, WAIT, DONE, ERR1, ERR2. From DONE, ERR2 or IDLE:
  - accept, legal → WAIT (or DONE if WAIT_STATES=0)
  - accept, illegal → ERR1
  - otherwise → IDLE
- Write: committed at the edge ending DONE. Only the bytes enabled by the lane mask (derived from HSIZE and the low address bits) are written from the matching HWDATA lanes. Other bytes are unchanged.
- Read:
  - Word read at the DONE edge preceding output; HRDATA is valid whenever HREADYout=1 in a read DONE.
  - Data is returned on its natural byte lanes; unselected lanes are driven 0, never replicated.
  - HRDATA=0 in all other cycles.
- Forwarding: if a read's data phase directly follows a write's data phase to the same word, HRDATA returns the merged value. Written bytes come from that write's HWDATA.
- Back-to-back: a new address phase may be accepted in the same cycle DONE/ERR2 completes. Pipelined throughput is one beat per (WAIT_STATES+1) cycles.
- HREADYin low with HSEL high: no accept; address/control are ignored until HREADYin=1.
- Address wrap: only HADDR[ADDR_BITS-1:log2(DATA_WIDTH/8)] indexes memory; upper bits are checked for range only.

Optional Feature:
- Macro: AHB_MEM_SEQ_FAST_EN
- Defined:
  - SEQ beats take zero wait states (page-mode) irrespective of WAIT_STATES; NONSEQ beats still insert WAIT_STATES.
  - An illegal SEQ beat still produces the two-cycle ERROR.
- Undefined: SEQ and NONSEQ beats both insert WAIT_STATES.

Test Plan:
- Reset, then idle bus → HREADYout=1, HRESP=00, HRDATA=0. Assert HRESET during a write DONE → that memory word keeps INIT_VALUE.
- DATA_WIDTH=32, WAIT_STATES=0: write word 0xDEADBEEF to 0x100, then byte write 0x55 to 0x102 (HWDATA=0x00550000) → word read of 0x100 returns 0xDE55BEEF. Half read at 0x102 returns 0xDE550000.
- WAIT_STATES=3: single NONSEQ read → HREADYout low exactly 3 cycles, data valid in cycle 4. With AHB_MEM_SEQ_FAST_EN, a 4-beat INCR read gives 3+1+1+1+1 cycles.
- Out-of-range read at 0x0010_0000 (ADDR_BITS=20), and half write at 0x101 → each gets ERR1 (HREADYout=0, HRESP=01), then ERR2 (HREADYout=1, HRESP=01); memory unchanged.
- Write 0x11223344 to 0x200, then immediately read 0x200 in the next address phase → read returns 0x11223344 (forwarded).
- DATA_WIDTH=64: dword write 0x0102030405060708 at 0x8, then byte read at 0xD → HRDATA=0x0000_0300_0000_0000. A dword with DATA_WIDTH=32 → ERROR.
